// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encoding,
// instruction opcode/funct values, ALU operation codes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_WB_R      = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_READ  = 4'd5,
        S_MEM_WB    = 4'd6,
        S_MEM_WRITE = 4'd7,
        S_EXEC_I    = 4'd8,
        S_WB_I      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_HALT      = 4'd14
    } state_t;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    // R-type funct codes (instruction bits [5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] ASB_B   = 2'b00;
    localparam logic [1:0] ASB_ONE = 2'b01;
    localparam logic [1:0] ASB_IMM = 2'b10;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational funct-to-ALUop translation for R-type arithmetic/logic ops.
// valid is low for any funct that is not an ALU operation (including jr).
module alu_op_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       valid
);

    // Map funct field onto the ALU operation code
    always_comb begin
        alu_op = ALUOP_ADD;
        valid  = 1'b1;
        case (func)
            FUNCT_ADD: alu_op = ALUOP_ADD;
            FUNCT_SUB: alu_op = ALUOP_SUB;
            FUNCT_AND: alu_op = ALUOP_AND;
            FUNCT_OR:  alu_op = ALUOP_OR;
            FUNCT_SLT: alu_op = ALUOP_SLT;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore-style control FSM for a multi-cycle MIPS-like datapath.
// Instructions take 3-5 cycles; inst_done marks the final cycle of each.
module multi_cycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       Jal,
    output logic       MemtoReg,
    output logic       toReg,
    output logic       ALUsrcA,
    output logic [1:0] ALUsrcB,
    output logic [1:0] PCsrc,
    output logic [2:0] ALUop,
    output logic       inst_done,
    output logic       halted
);

    state_t     state_reg;
    state_t     state_next;
    state_t     dispatch_state;
    logic       dispatch_illegal;
    logic       slti_reg;
    logic       slti_next;
    logic [2:0] funct_alu_op;
    logic       funct_valid;

    alu_op_decoder u_alu_op_decoder (
        .func   (func),
        .alu_op (funct_alu_op),
        .valid  (funct_valid)
    );

    // Decode-stage dispatch target for the current instruction word
    always_comb begin
        dispatch_state   = S_FETCH;
        dispatch_illegal = 1'b0;
        case (opc)
            OPC_RTYPE: begin
                if (func == FUNCT_JR)
                    dispatch_state = S_JR;
                else if (funct_valid)
                    dispatch_state = S_EXEC_R;
                else
                    dispatch_illegal = 1'b1;
            end
            OPC_LW, OPC_SW:     dispatch_state = S_MEM_ADDR;
            OPC_BEQ:            dispatch_state = S_BRANCH;
            OPC_ADDI, OPC_SLTI: dispatch_state = S_EXEC_I;
            OPC_J:              dispatch_state = S_JUMP;
            OPC_JAL:            dispatch_state = S_JAL;
            default:            dispatch_illegal = 1'b1;
        endcase
        if (dispatch_illegal)
            dispatch_state = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
    end

    // Next-state sequencing; the slti flag keeps EXEC_I outputs state-only
    always_comb begin
        state_next = state_reg;
        slti_next  = slti_reg;
        case (state_reg)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                state_next = dispatch_state;
                slti_next  = (opc == OPC_SLTI);
            end
            S_EXEC_R:   state_next = S_WB_R;
            S_MEM_ADDR: state_next = (opc == OPC_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_next = S_MEM_WB;
            S_EXEC_I:   state_next = S_WB_I;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    // State register with synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            slti_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            slti_reg  <= slti_next;
        end
    end

    // Per-state control outputs; enables, done and halted are masked in reset
    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        Jal       = 1'b0;
        MemtoReg  = 1'b0;
        toReg     = 1'b0;
        ALUsrcA   = 1'b0;
        ALUsrcB   = ASB_B;
        PCsrc     = PCS_ALU;
        ALUop     = ALUOP_AND;
        inst_done = 1'b0;
        halted    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUsrcB = ASB_ONE;
                ALUop   = ALUOP_ADD;
                PCsrc   = PCS_ALU;
            end
            S_DECODE: begin
                ALUsrcB   = ASB_IMM;
                ALUop     = ALUOP_ADD;
                inst_done = dispatch_illegal && !TRAP_ON_ILLEGAL;
            end
            S_EXEC_R: begin
                ALUsrcA = 1'b1;
                ALUsrcB = ASB_B;
                ALUop   = funct_alu_op;
            end
            S_WB_R: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                toReg     = 1'b1;
                inst_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = ASB_IMM;
                ALUop   = ALUOP_ADD;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                toReg     = 1'b1;
                MemtoReg  = 1'b1;
                inst_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                inst_done = 1'b1;
            end
            S_EXEC_I: begin
                ALUsrcA = 1'b1;
                ALUsrcB = ASB_IMM;
                ALUop   = slti_reg ? ALUOP_SLT : ALUOP_ADD;
            end
            S_WB_I: begin
                RegWrite  = 1'b1;
                toReg     = 1'b1;
                inst_done = 1'b1;
            end
            S_BRANCH: begin
                ALUsrcA   = 1'b1;
                ALUsrcB   = ASB_B;
                ALUop     = ALUOP_SUB;
                PCsrc     = PCS_ALUOUT;
                PCWrite   = zero;
                inst_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCsrc     = PCS_JUMP;
                inst_done = 1'b1;
            end
            S_JAL: begin
                PCWrite   = 1'b1;
                PCsrc     = PCS_JUMP;
                RegWrite  = 1'b1;
                Jal       = 1'b1;
                inst_done = 1'b1;
            end
            S_JR: begin
                PCWrite   = 1'b1;
                PCsrc     = PCS_REGA;
                inst_done = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b0;
        endcase
        if (rst) begin
            PCWrite   = 1'b0;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            inst_done = 1'b0;
            halted    = 1'b0;
        end
    end

endmodule
